// File: rtl/ecc_op_sequencer.sv
// ecc_op_sequencer
// APB-programmed controller that drives a shared ECC encoder/decoder core
// through Encode (CTRL=0), Decode (CTRL=1) and Full Channel (CTRL=2:
// encode, XOR with NOISE, decode) operations.
//
// Ports:
//   PCLK, rst             clock, asynchronous active-high reset
//   PADDR/PSEL/PENABLE/   APB slave (no wait states); PADDR[3:2] selects
//   PWRITE/PWDATA/PRDATA  CTRL, DATA, CODEWORD_WIDTH, NOISE
//   core_start/mode/      start pulse, 0=encode 1=decode, width code and
//   width/din             masked operand presented to the core
//   core_done/dout/nerr   core result handshake
//   data_out/             latched result and error count, held until the
//   num_of_errors         next completed operation
//   operation_done        one-cycle completion pulse
//   busy                  high from start through the completion cycle
module ecc_op_sequencer #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       PCLK,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       core_start,
  output logic                       core_mode,
  output logic [1:0]                 core_width,
  output logic [DATA_WIDTH-1:0]      core_din,
  input  logic                       core_done,
  input  logic [DATA_WIDTH-1:0]      core_dout,
  input  logic [1:0]                 core_nerr,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_E, S_WAIT_E, S_ISSUE_D, S_WAIT_D, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_ctrl;
  logic [1:0]            r_width;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_noise;
  logic [DATA_WIDTH-1:0] r_codeword;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [1:0]            r_nerr;

  logic                  w_busy;
  logic                  w_wr_en;
  logic                  w_start;
  logic [1:0]            w_addr;
  logic [DATA_WIDTH-1:0] w_mask;

  // Address bits outside the decoded window are intentionally ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};

  assign w_addr  = PADDR[3:2];
  assign w_busy  = (r_state != S_IDLE);
  // Every register is write-protected for the whole operation, DONE included.
  assign w_wr_en = PSEL & PENABLE & PWRITE & ~w_busy;
  // CTRL=3 is stored but never launches anything.
  assign w_start = w_wr_en && (w_addr == 2'd0) && (PWDATA[1:0] != 2'd3);

  always_comb begin
    w_mask = '1;
    case (r_width)
      2'd0:    w_mask = DATA_WIDTH'(8'hFF);
      2'd1:    w_mask = DATA_WIDTH'(16'hFFFF);
      default: w_mask = '1;
    endcase
  end

  // Register file.
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_data  <= '0;
      r_width <= '0;
      r_noise <= '0;
    end else if (w_wr_en) begin
      case (w_addr)
        2'd0: r_ctrl  <= PWDATA[1:0];
        2'd1: r_data  <= PWDATA[DATA_WIDTH-1:0];
        2'd2: r_width <= PWDATA[1:0];
        2'd3: r_noise <= PWDATA[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (w_addr)
        2'd0:    PRDATA = AMBA_WORD'(r_ctrl);
        2'd1:    PRDATA = AMBA_WORD'(r_data);
        2'd2:    PRDATA = AMBA_WORD'(r_width);
        default: PRDATA = AMBA_WORD'(r_noise);
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and core-facing outputs. Operand and mode are derived from
  // state plus registers that cannot change while busy, so they stay stable
  // from ISSUE through WAIT without extra holding registers.
  always_comb begin
    w_state_next = r_state;
    core_start   = 1'b0;
    core_mode    = 1'b0;
    core_din     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start)
          w_state_next = (PWDATA[1:0] == 2'd1) ? S_ISSUE_D : S_ISSUE_E;
      end
      S_ISSUE_E, S_WAIT_E: begin
        core_start = (r_state == S_ISSUE_E);
        core_din   = r_data & w_mask;
        if (r_state == S_ISSUE_E)
          w_state_next = S_WAIT_E;
        else if (core_done)
          w_state_next = (r_ctrl == 2'd2) ? S_ISSUE_D : S_DONE;
      end
      S_ISSUE_D, S_WAIT_D: begin
        core_start = (r_state == S_ISSUE_D);
        core_mode  = 1'b1;
        core_din   = ((r_ctrl == 2'd2) ? (r_codeword ^ r_noise) : r_data) & w_mask;
        if (r_state == S_ISSUE_D)
          w_state_next = S_WAIT_D;
        else if (core_done)
          w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Full Channel keeps the encoded word for the noisy decode pass; results
  // are captured on the transition into DONE and held afterwards.
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      r_codeword <= '0;
      r_data_out <= '0;
      r_nerr     <= '0;
    end else begin
      if (r_state == S_WAIT_E && core_done && r_ctrl == 2'd2)
        r_codeword <= core_dout;
      if (w_state_next == S_DONE && r_state != S_DONE) begin
        r_data_out <= core_dout;
        r_nerr     <= (r_state == S_WAIT_D) ? core_nerr : 2'd0;
      end
    end
  end

  assign core_width     = r_width;
  assign data_out       = r_data_out;
  assign num_of_errors  = r_nerr;
  assign operation_done = (r_state == S_DONE);
  assign busy           = w_busy;

endmodule

// File: tb/tb_ecc_op_sequencer.sv
module tb_ecc_op_sequencer;
  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;

  logic           PCLK = 1'b0;
  logic           rst  = 1'b1;
  logic [ADW-1:0] PADDR = '0;
  logic           PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0]  PWDATA = '0;
  logic [AW-1:0]  PRDATA;
  logic           core_start, core_mode;
  logic [1:0]     core_width;
  logic [DW-1:0]  core_din;
  logic           core_done = 1'b0;
  logic [DW-1:0]  core_dout = '0;
  logic [1:0]     core_nerr = '0;
  logic [DW-1:0]  data_out;
  logic [1:0]     num_of_errors;
  logic           operation_done, busy;

  ecc_op_sequencer #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) dut (
    .PCLK(PCLK), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .core_start(core_start), .core_mode(core_mode), .core_width(core_width),
    .core_din(core_din), .core_done(core_done), .core_dout(core_dout),
    .core_nerr(core_nerr), .data_out(data_out), .num_of_errors(num_of_errors),
    .operation_done(operation_done), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model (operation level) ----------------
  logic [1:0]  m_ctrl = '0, m_width = '0;
  logic [31:0] m_data = '0, m_noise = '0;
  bit          m_active = 1'b0;
  int          m_e0 = 0, m_L = 0, m_dcyc = 0;
  logic [1:0]  m_op = '0;
  logic [31:0] m_dout = '0;
  logic [1:0]  m_nerr = '0;

  // ---------------- core stub ----------------
  int          stub_lat = 3;
  bit          stub_fix = 1'b0;
  logic [31:0] stub_fix_dout = '0;
  logic [1:0]  stub_fix_nerr = '0;
  int          st_rem = 0;
  logic        st_mode = 1'b0;
  logic [31:0] stub_enc_dout = '0, stub_last_dout = '0;
  logic [1:0]  stub_last_nerr = '0;

  // ---------------- monitors ----------------
  int          start_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  logic [31:0] last_start_din = '0;
  logic        last_start_mode = 1'b0;

  function automatic bit m_busy(input int k);
    return m_active && (k >= m_e0) && (k <= m_dcyc);
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] w);
    case (w)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, m_ctrl};
      2'd1:    return m_data;
      2'd2:    return {30'd0, m_width};
      default: return m_noise;
    endcase
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ctrl = '0; m_width = '0; m_data = '0; m_noise = '0;
    m_dout = '0; m_nerr = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then the core stub reacts.
  always @(negedge PCLK) begin
    int          k;
    bit          mb, in_done, dec_phase, exp_start;
    logic [31:0] exp_din;
    logic        exp_mode;
    k = cyc;
    mb = m_busy(k);
    in_done = m_active && (k == m_dcyc);
    if (in_done) begin
      m_dout = stub_last_dout;
      m_nerr = (m_op == 2'd0) ? 2'd0 : stub_last_nerr;
    end
    exp_start = m_active && ((k == m_e0) || (m_op == 2'd2 && k == m_e0 + m_L + 1));
    dec_phase = (m_op == 2'd1) || (m_op == 2'd2 && k >= m_e0 + m_L + 1);
    exp_mode  = 1'b0;
    exp_din   = '0;
    if (mb && dec_phase) begin
      exp_mode = 1'b1;
      exp_din  = ((m_op == 2'd1) ? m_data : (stub_enc_dout ^ m_noise)) & width_mask(m_width);
    end else if (mb) begin
      exp_din  = m_data & width_mask(m_width);
    end
    chk("busy", busy, mb);
    chk("operation_done", operation_done, in_done);
    chk("core_start", core_start, exp_start);
    chk("core_width", core_width, m_width);
    chk("data_out", data_out, m_dout);
    chk("num_of_errors", num_of_errors, m_nerr);
    chk("PRDATA", PRDATA, (PSEL && !PWRITE) ? m_reg(PADDR[3:2]) : 32'd0);
    if (!in_done) begin
      chk("core_mode", core_mode, exp_mode);
      chk("core_din", core_din, exp_din);
    end
    if (core_start) begin
      start_cnt++;
      last_start_din  = core_din;
      last_start_mode = core_mode;
    end
    if (operation_done) begin
      done_cnt++;
      last_done_cyc = k;
    end
    // Core stub: done is raised so that it is sampled L edges after the
    // edge that sampled core_start.
    core_done = 1'b0;
    if (st_rem > 0) begin
      st_rem--;
      if (st_rem == 0) begin
        core_done = 1'b1;
        core_dout = stub_fix ? stub_fix_dout : $urandom;
        core_nerr = stub_fix ? stub_fix_nerr : 2'($urandom_range(0, 2));
        stub_last_dout = core_dout;
        stub_last_nerr = core_nerr;
        if (!st_mode) stub_enc_dout = core_dout;
      end
    end
    if (core_start && !rst) begin
      st_rem  = stub_lat;
      st_mode = core_mode;
    end
  end

  // ---------------- APB driver ----------------
  task automatic apb_write(input logic [1:0] a, input logic [31:0] d, output int c);
    @(posedge PCLK); #1;
    PADDR = ADW'($urandom); PADDR[3:2] = a;
    PWDATA = d; PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    c = cyc;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    if (!rst && !m_busy(c - 1)) begin
      case (a)
        2'd0: m_ctrl  = d[1:0];
        2'd1: m_data  = d;
        2'd2: m_width = d[1:0];
        default: m_noise = d;
      endcase
      if (a == 2'd0 && d[1:0] != 2'd3) begin
        m_active = 1'b1;
        m_e0 = c;
        m_op = d[1:0];
        m_L  = stub_lat;
        m_dcyc = (d[1:0] == 2'd2) ? c + 2 * stub_lat + 2 : c + stub_lat + 1;
      end
    end
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PADDR = ADW'($urandom); PADDR[3:2] = a;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy(cyc) || busy) && n < 200) begin
      @(posedge PCLK); #1;
      n++;
    end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    logic [31:0] rd;
    int          r;
    logic [1:0]  a;

    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_operation_done", operation_done, 0);
    rst = 1'b0;

    // Encode, 8-bit width, core latency 3.
    stub_lat = 3; stub_fix = 1'b1; stub_fix_dout = 32'hCAFE_0011; stub_fix_nerr = 2'd2;
    apb_write(2'd2, 32'd0, c);
    apb_write(2'd1, 32'h0000_01A5, c);
    start_cnt = 0; done_cnt = 0;
    apb_write(2'd0, 32'd0, c);
    wait_idle();
    chk("enc8_din", last_start_din, 32'h0000_00A5);
    chk("enc8_mode", last_start_mode, 0);
    chk("enc8_latency", last_done_cyc - c, 4);
    chk("enc8_done_cnt", done_cnt, 1);
    chk("enc8_data_out", data_out, 32'hCAFE_0011);
    chk("enc8_nerr", num_of_errors, 0);

    // Full Channel, 16-bit width, noise on bit 2.
    stub_fix_dout = 32'h0001_2345; stub_fix_nerr = 2'd1;
    apb_write(2'd2, 32'd1, c);
    apb_write(2'd1, 32'h0000_BEEF, c);
    apb_write(2'd3, 32'h0000_0004, c);
    start_cnt = 0; done_cnt = 0;
    apb_write(2'd0, 32'd2, c);
    wait_idle();
    chk("fc16_start_cnt", start_cnt, 2);
    chk("fc16_dec_din", last_start_din, 32'h0000_2341);
    chk("fc16_dec_mode", last_start_mode, 1);
    chk("fc16_latency", last_done_cyc - c, 8);
    chk("fc16_done_cnt", done_cnt, 1);
    chk("fc16_nerr", num_of_errors, 1);
    chk("fc16_data_out", data_out, 32'h0001_2345);
    stub_fix = 1'b0;

    // Register readback.
    apb_write(2'd1, 32'd56456, c);
    apb_write(2'd2, 32'd1, c);
    apb_write(2'd3, 32'd56399544, c);
    apb_write(2'd0, 32'd2, c);
    wait_idle();
    apb_read(2'd0, rd); chk("rb_ctrl", rd, 32'd2);
    apb_read(2'd1, rd); chk("rb_data", rd, 32'd56456);
    apb_read(2'd2, rd); chk("rb_width", rd, 32'd1);
    apb_read(2'd3, rd); chk("rb_noise", rd, 32'd56399544);

    // Busy protection: DATA write during WAIT, CTRL write lands in DONE.
    stub_lat = 4;
    start_cnt = 0;
    apb_write(2'd0, 32'd0, c);
    apb_write(2'd1, 32'hFFFF_FFFF, c);
    apb_write(2'd0, 32'd1, c);
    wait_idle();
    repeat (3) @(posedge PCLK);
    #1;
    chk("busy_start_cnt", start_cnt, 1);
    apb_read(2'd1, rd); chk("busy_data_kept", rd, 32'd56456);
    apb_read(2'd0, rd); chk("busy_ctrl_kept", rd, 32'd0);

    // Reserved CTRL value.
    start_cnt = 0;
    apb_write(2'd0, 32'd3, c);
    repeat (5) @(posedge PCLK);
    #1;
    chk("ctrl3_start_cnt", start_cnt, 0);
    chk("ctrl3_busy", busy, 0);
    apb_read(2'd0, rd); chk("ctrl3_readback", rd, 32'd3);

    // Reset during WAIT_D; the stub still fires done afterwards.
    stub_lat = 4;
    apb_write(2'd0, 32'd1, c);
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    rst = 1'b1;
    model_reset();
    done_cnt = 0;
    @(posedge PCLK); #1;
    rst = 1'b0;
    repeat (8) @(posedge PCLK);
    #1;
    chk("rstmid_done_cnt", done_cnt, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_data_out", data_out, 0);

    // Randomized traffic: operations, reads, and writes racing busy/DONE.
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      a = 2'($urandom_range(1, 3));
      if (r < 3) begin
        if (!m_busy(cyc)) stub_lat = $urandom_range(1, 4);
        apb_write(2'd0, {$urandom} & 32'hFFFF_FFF3 | 32'($urandom_range(0, 3)), c);
      end else if (r < 7) begin
        apb_write(a, $urandom, c);
      end else begin
        apb_read(2'($urandom_range(0, 3)), rd);
      end
      repeat ($urandom_range(0, 2)) @(posedge PCLK);
    end
    wait_idle();
    repeat (2) @(posedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
